// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its read-select tree.
// Defaults match the core's 32 x 32-bit integer register set.
package regfile_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Index of the word that reads as zero when the hardwired-zero option is on.
  localparam int ZERO_WORD = 0;

  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mux_tree.sv
// Binary DEPTH:1 word selector: level l picks between sibling pairs using sel[l],
// LSB first, so the path depth is exactly ADDR_W 2:1 stages.
module mux_tree
  import regfile_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic [DEPTH*N-1:0] data,
  input  logic [ADDR_W-1:0]  sel,
  output logic [N-1:0]       out
);

  logic [N-1:0] node [DEPTH];

  // Each level is folded in place: node[k] takes node[2k] or node[2k+1], and
  // since 2k >= k the sources of a level are always read before being replaced.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      node[k] = data[k*N +: N];
    end
    for (int l = 0; l < ADDR_W; l++) begin
      for (int k = 0; k < (DEPTH >> (l + 1)); k++) begin
        node[k] = sel[l] ? node[2*k+1] : node[2*k];
      end
    end
    out = node[0];
  end

endmodule

// File: rtl/register_file.sv
// Decode-stage register file: DEPTH x N storage, one synchronous write port,
// two combinational read ports with optional hardwired zero word and write bypass.
module register_file
  import regfile_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]      rd_data0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]      rd_data1
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_WORD);

  logic [N-1:0]       mem [DEPTH];
  logic [DEPTH*N-1:0] mem_flat;
  logic [N-1:0]       tree0;
  logic [N-1:0]       tree1;
  logic               wr_fire;
  logic               bypass_on;
  logic               hit0;
  logic               hit1;

  function automatic logic is_zero_word(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == ZERO_ADDR);
  endfunction

  assign wr_fire = wr_ena && !is_zero_word(wr_addr);

  // NOTE: every word is a flop that must read 0 straight out of reset, so the
  // whole array sits in the async reset branch; non-blocking (<=) is used for all
  // sequential state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_flat[i*N +: N] = mem[i];
    end
  end

  mux_tree #(.N(N), .DEPTH(DEPTH)) u_tree0 (
    .data (mem_flat),
    .sel  (rd_addr0),
    .out  (tree0)
  );

  mux_tree #(.N(N), .DEPTH(DEPTH)) u_tree1 (
    .data (mem_flat),
    .sel  (rd_addr1),
    .out  (tree1)
  );

  // Bypass is gated by rst_n so a pending write cannot leak out during reset.
  assign bypass_on = (BYPASS != 0) && wr_fire && rst_n;
  assign hit0      = bypass_on && (rd_addr0 == wr_addr);
  assign hit1      = bypass_on && (rd_addr1 == wr_addr);

  // NOTE: each output gets its default first, so no path through the block can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data0 = tree0;
    if (is_zero_word(rd_addr0)) begin
      rd_data0 = '0;
    end else if (hit0) begin
      rd_data0 = wr_data;
    end
  end

  always_comb begin
    rd_data1 = tree1;
    if (is_zero_word(rd_addr1)) begin
      rd_data1 = '0;
    end else if (hit1) begin
      rd_data1 = wr_data;
    end
  end

endmodule
